// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_HALF = 1'b1;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic        write;
    logic        size;
    logic        zext;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_if.sv
// MEM-stage request/response bundle between the CPU and the data memory.
interface dmem_if;

  logic        req_valid;
  logic        req_write;
  logic        req_size;
  logic        req_zext;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  modport master (
    output req_valid,
    output req_write,
    output req_size,
    output req_zext,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err,
    input  stall
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_size,
    input  req_zext,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err,
    output stall
  );

endinterface

// File: rtl/dmem_lane_merge.sv
// Byte-lane write merge and read-lane extraction for a 16-bit word.
module dmem_lane_merge
  import dmem_pkg::*;
(
  input  logic [15:0] old_word,
  input  logic [15:0] wdata,
  input  logic        size,
  input  logic        lane,
  input  logic        zext,
  output logic [15:0] wr_word,
  output logic [15:0] rd_data
);

  logic [7:0]  byte_v;
  logic [15:0] ext_v;

  always_comb begin
    byte_v = lane ? old_word[15:8] : old_word[7:0];
    ext_v  = zext ? {8'h00, byte_v}
                  : {{8{byte_v[7]}}, byte_v};
  end

  always_comb begin
    wr_word = old_word;
    rd_data = '0;
    unique case ({size, lane})
      {SIZE_BYTE, 1'b0}: begin
        wr_word = {old_word[15:8], wdata[7:0]};
        rd_data = ext_v;
      end
      {SIZE_BYTE, 1'b1}: begin
        wr_word = {wdata[7:0], old_word[7:0]};
        rd_data = ext_v;
      end
      default: begin
        wr_word = wdata;
        rd_data = old_word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_target.sv
// Word-organised 16-bit data memory with byte/half access and wait states.
module dmem_target
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input logic   clock,
  input logic   reset,
  dmem_if.slave bus
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e state_q;
  state_e state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  req_t req_q;
  req_t live;
  req_t cur;

  logic [15:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          commit;
  logic          err;
  logic          do_write;
  logic [AW-1:0] idx;
  logic [15:0]   old_word;
  logic [15:0]   wr_word;
  logic [15:0]   rd_data;

  logic        rsp_valid_q;
  logic [15:0] rsp_rdata_q;
  logic        rsp_err_q;

  assign live = '{
    write: bus.req_write,
    size:  bus.req_size,
    zext:  bus.req_zext,
    addr:  bus.req_addr,
    wdata: bus.req_wdata
  };

  // With zero wait states the access commits on the accepting edge,
  // before the latched copy exists, so decode from the live inputs.
  assign cur = (state_q == IDLE) ? live : req_q;

  assign accept = (state_q == IDLE) && bus.req_valid;
  assign idx = cur.addr[AW:1];
  assign old_word = mem[idx];

  assign err =
    ({1'b0, cur.addr[15:1]} >= 16'(DEPTH_WORDS)) ||
    ((cur.size == SIZE_HALF) && cur.addr[0]);

  assign do_write = commit && cur.write && !err;

  dmem_lane_merge u_lane (
    .old_word (old_word),
    .wdata    (cur.wdata),
    .size     (cur.size),
    .lane     (cur.addr[0]),
    .zext     (cur.zext),
    .wr_word  (wr_word),
    .rd_data  (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_d = CNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= commit;
      rsp_err_q   <= commit && err;
      rsp_rdata_q <= (commit && !err && !cur.write)
                   ? rd_data : 16'h0000;
      if (accept) begin
        req_q <= live;
      end
    end
  end

  // Storage carries no reset; contents are undefined until written.
  always_ff @(posedge clock) begin
    if (do_write) begin
      mem[idx] <= wr_word;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.stall     = accept || (state_q == WAIT);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_target.md
# dmem_target

Multi-cycle data-memory responder that services load/store requests issued by the CPU MEM stage. It holds a word-organised 16-bit store, supports byte and halfword accesses with sign or zero extension, and inserts a parameterised number of wait states. While an access is in flight it raises `stall` toward the hazard logic, and it returns each result with a single-cycle response strobe.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 16-bit words; must be a power of two, at most 32768.
- `WAIT_STATES`, 2: cycles between acceptance and response; range 0..15.

Ports:
- `clock`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `req_valid`, in, 1: request present.
- `req_write`, in, 1: 1 = store, 0 = load.
- `req_size`, in, 1: 0 = byte, 1 = halfword.
- `req_zext`, in, 1: byte load only; 1 = zero-extend, 0 = sign-extend.
- `req_addr`, in, 16: byte address.
- `req_wdata`, in, 16: store data; a byte store uses bits [7:0].
- `req_ready`, out, 1: request can be accepted this cycle.
- `rsp_valid`, out, 1: one-cycle response strobe.
- `rsp_rdata`, out, 16: load result; 0 for stores and errors.
- `rsp_err`, out, 1: access was misaligned or out of range; valid with `rsp_valid`.
- `stall`, out, 1: hold the pipeline.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - When `req_valid`=1, latch all `req_*` fields.
  - Load the wait counter with `WAIT_STATES`.
  - Go to WAIT, or go straight to RESP if `WAIT_STATES`=0. In that case the access commits on the accepting edge.
- WAIT:
  - The counter decrements each cycle.
  - On the edge where it reaches 0, commit the access and go to RESP.
- RESP:
  - `rsp_valid`=1 for exactly one cycle, then return to IDLE.
  - No request is accepted in RESP.
- Address decode:
  - Word index is `addr[15:1]`.
  - Byte lane is `addr[0]`: little-endian, lane 0 = bits [7:0].
- Errors:
  - Out of range: word index ≥ `DEPTH_WORDS`.
  - Misaligned: halfword access with `addr[0]`=1.
  - On error: no write occurs, `rsp_rdata`=0, `rsp_err`=1.
- Byte store: modifies only the selected lane; the other lane is preserved.
- Halfword load returns the full word. Byte load returns the selected lane, extended per `req_zext`.
- Request inputs are ignored outside IDLE. The latched copy is authoritative.
- `stall` = (IDLE ∧ `req_valid`) ∨ WAIT. `stall` is 0 in RESP, so the pipeline advances on the response cycle.
- Storage is not reset; contents are undefined until written.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0. `stall`=0 unless `req_valid` is high.
- Latency: a request accepted at edge N produces `rsp_valid` in the cycle after edge N+`WAIT_STATES`. Throughput is one access per `WAIT_STATES`+2 cycles.
- Stores commit at the edge entering RESP, so a following load sees the new data.
- Reset asserted during WAIT:
  - Immediate return to IDLE.
  - A pending store is dropped and memory is unchanged.
  - No response is produced.
- Reset asserted during RESP: the strobe is cut immediately. The store has already committed.
- `req_valid` held high through RESP: the request is accepted again in the following IDLE cycle. The requester must drop `req_valid` on `rsp_valid`.
- All outputs except `stall` and `req_ready` are registered. Those two are combinational from state and `req_valid`.

## Structure
- Package `dmem_pkg`:
  - state enum (IDLE/WAIT/RESP);
  - `SIZE_BYTE`=0 and `SIZE_HALF`=1;
  - wait-counter width constant (4).
- Sub-module `dmem_lane_merge`, combinational:
  - write-merge of byte lanes;
  - read-lane extraction with sign or zero extension.
- The FSM, counter and storage array live in the top module.

## Test plan
- Halfword store then load, `WAIT_STATES`=2:
  - Stimulus: store 0xBEEF to 0x0010, then load 0x0010.
  - Response: each access gives `rsp_valid` 3 cycles after acceptance; load returns `rsp_rdata`=0xBEEF; `stall` is high for 3 cycles per access.
- Byte lanes and extension:
  - Stimulus: store 0x1234 at 0x0020; byte store 0x80 at 0x0021; byte load 0x0021 with zext=0, then with zext=1; halfword load 0x0020.
  - Response: 0xFF80, then 0x0080, then 0x8034.
- Errors:
  - Halfword load at 0x0003 → `rsp_err`=1, `rsp_rdata`=0.
  - Store to 0x0200 with `DEPTH_WORDS`=256 → `rsp_err`=1, memory unchanged.
- Zero wait states:
  - Stimulus: `WAIT_STATES`=0; load accepted at edge N.
  - Response: `rsp_valid` in the cycle after N; `req_ready`=0 in that cycle; next request accepted one cycle later.
- Reset mid-WAIT:
  - Stimulus: store 0xAAAA to 0x0004 over an existing 0x5555; pulse `reset` low during WAIT.
  - Response: no `rsp_valid`; a later load of 0x0004 returns 0x5555.
- Input changes during WAIT:
  - Stimulus: modify `req_addr` and `req_wdata` while in WAIT.
  - Response: the access uses the originally latched values.
